instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage directly upstream of the decode/ALU-control logic.
- Owns the PC and issues read requests to instruction memory with a request/ready handshake.
- Latches the returned 16-bit word into an instruction register. Holds it stable, with instr_valid asserted, until the execute side commands the next PC.
- The held instruction feeds opcode decode, ALU function selection and register-file addressing.

Parameters:
WORD_WIDTH, 16, width of instruction, PC and memory address/data
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
mem_read  output  1  instruction-memory read request (registered)
mem_addr  output  WORD_WIDTH  read address; registered copy of pc
mem_data  input  WORD_WIDTH  instruction word returned by memory
mem_ready  input  1  memory strobe: mem_data valid this cycle
next_pc  input  WORD_WIDTH  PC computed by execute stage (PC+1, branch or jump target)
pc_update  input  1  one-cycle strobe: current instruction retired, load next_pc
halt  input  1  halt request from decode (HLT instruction)
instr  output  WORD_WIDTH  instruction register to decode/alu control
instr_valid  output  1  instr holds a fetched, not-yet-retired instruction
pc  output  WORD_WIDTH  address of the instruction in instr
fetch_count  output  WORD_WIDTH  number of completed fetches
halted  output  1  unit is in HALTED state

Behaviour:
- Reset is synchronous and active-high. While reset=1 at a clock edge, the edge forces:
  - state=IDLE, pc=RESET_PC, mem_addr=RESET_PC
  - mem_read=0, instr=0, instr_valid=0
  - fetch_count=0, halted=0
- Reset asserted mid-fetch aborts the fetch. mem_read is 0 after that edge, and a mem_ready arriving in the same cycle is ignored.
- State machine: IDLE, FETCH, VALID, HALTED. State is registered; all outputs are registered.
- IDLE -> FETCH unconditionally on the first edge after reset deasserts. This sets mem_read=1 and mem_addr=pc.
- FETCH: mem_read stays 1 and mem_addr stays constant until mem_ready=1 is sampled. Wait states are unbounded. On the edge where mem_ready=1:
  - instr <= mem_data
  - instr_valid <= 1
  - mem_read <= 0
  - fetch_count <= fetch_count+1
  - state -> VALID
- Fetch latency: mem_ready sampled at edge N means instr/instr_valid are valid after edge N. A zero-wait memory (mem_ready=1 in the first request cycle) gives 1 cycle from request to instr_valid.
- VALID: instr, pc and instr_valid=1 are held stable.
  - pc_update=1 and halt=0: pc <= next_pc, mem_addr <= next_pc, instr_valid <= 0, mem_read <= 1, state -> FETCH. instr keeps the old value but is invalid. The minimum gap between instructions is therefore 1 request cycle.
  - halt=1 (with or without pc_update): state -> HALTED, instr_valid <= 0, halted <= 1, pc not updated. Halt has priority.
- HALTED: no further requests (mem_read=0). pc, instr and fetch_count are frozen. The state is left only by reset.
- Ignored inputs:
  - mem_ready outside FETCH
  - pc_update and halt outside VALID
- fetch_count wraps 16'hFFFF -> 16'h0000 without a flag.
- PC arithmetic is not performed here. next_pc is taken verbatim, and all values are legal, including wrap to 0.

Test Plan:
- Reset, then memory returns 16'h6A05 with mem_ready in the first FETCH cycle -> mem_read high one cycle after reset release, mem_addr=0000, then instr=6A05, instr_valid=1, fetch_count=1, mem_read=0.
- Memory stalls 3 cycles before mem_ready with data 16'h4123 -> mem_read and mem_addr held constant for 4 cycles, instr_valid=0 throughout, then instr=4123 on the edge after mem_ready.
- In VALID, pulse pc_update with next_pc=16'h0010 -> next edge pc=0010, mem_addr=0010, mem_read=1, instr_valid=0. A spurious mem_ready pulse while in VALID beforehand does not change instr.
- halt and pc_update together in VALID (pc=0005) -> halted=1, instr_valid=0, pc stays 0005, no further mem_read for 10 cycles.
- Assert reset during a stalled FETCH at pc=0020, with mem_ready=1 in the same cycle -> pc=0000, mem_read=0, instr=0, fetch_count=0. Fetch restarts at 0000 after release.
- Preload fetch_count near wrap (run 65535 fetches or force) -> the next completed fetch rolls 16'hFFFF to 16'h0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle fetch stage owning the PC, fetching words from instruction memory via request/ready
// Ports: clk/reset (sync, active-high); mem_read/mem_addr out, mem_data/mem_ready in (memory side);
//        next_pc/pc_update/halt in (execute/decode side); instr/instr_valid/pc/fetch_count/halted out.
module instr_fetch_unit #(
  parameter int WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_read,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  input  logic [WORD_WIDTH-1:0] next_pc,
  input  logic                  pc_update,
  input  logic                  halt,
  output logic [WORD_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] fetch_count,
  output logic                  halted
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALTED} state_t;
  localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, cnt_q, cnt_d;
  logic rd_q, rd_d, valid_q, valid_d, halted_q, halted_d;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        rd_d    = 1'b1;
        addr_d  = pc_q;
      end
      FETCH: if (mem_ready) begin
        state_d = VALID;
        instr_d = mem_data;
        valid_d = 1'b1;
        rd_d    = 1'b0;
        cnt_d   = cnt_q + ONE;
      end
      // halt wins over pc_update; pc stays at the halting instruction
      VALID: if (halt) begin
        state_d  = HALTED;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end else if (pc_update) begin
        state_d = FETCH;
        pc_d    = next_pc;
        addr_d  = next_pc;
        valid_d = 1'b0;
        rd_d    = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      instr_q  <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end
  assign mem_read    = rd_q;
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_count = cnt_q;
  assign halted      = halted_q;
endmodule
